bypass_subtractor_seq: RTL and testbench
========================================

# bypass_subtractor_seq

Sequential signed subtractor that computes `a - b - bin` one carry-bypass block per clock. It is the inverse-operation companion to the team's carry bypass adder. Operands are accepted over a valid/ready handshake and the 32-bit result is held until it is consumed. Each block either ripples its carry or bypasses it when the block fully propagates. A per-operation skip counter exposes how many blocks took the bypass path.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; must be a multiple of `BLOCK`.
- `BLOCK`, 4: bits processed per cycle (bypass block size).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `in_valid`  in  1  operand set valid.
- `in_ready`  out  1  block can accept operands (high only in IDLE).
- `a`  in  WIDTH  signed minuend.
- `b`  in  WIDTH  signed subtrahend.
- `bin`  in  1  borrow in.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `diff`  out  WIDTH  signed result.
- `bout`  out  1  unsigned borrow out (= NOT final carry).
- `overflow`  out  1  signed overflow.
- `skip_cnt`  out  $clog2(WIDTH/BLOCK)+1  number of bypassed blocks in the current result.
- `busy`  out  1  high in CALC or DONE.

## Operation
- Arithmetic:
  - `diff = a + ~b + ~bin`, computed with carry-in `c0 = ~bin`.
  - `bout = ~c_final`.
  - `overflow = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1])`.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - `in_ready = 1`.
  - When `in_valid` is high, latch `a`, `~b` and `c = ~bin`; clear `blk_idx` and `skip_cnt`; go to CALC.
- CALC: each cycle processes block `i = blk_idx`, bits `[i*BLOCK +: BLOCK]`.
  - Compute `p = a_blk ^ nb_blk` and `g = a_blk & nb_blk`.
  - If `&p`: carry out = carry in (bypass); increment `skip_cnt`. Sum bits = `p ^ carry chain`, which equals `~p`-adjusted ripple output; the sum is still written.
  - Otherwise: ripple carry through the block.
  - Write the result slice into `diff`.
  - After the last block (`blk_idx == WIDTH/BLOCK-1`), compute `overflow` and `bout`, then go to DONE.
- DONE:
  - `out_valid = 1`.
  - `diff`, `bout`, `overflow` and `skip_cnt` are held stable until `out_ready`.
  - On `out_ready`, go to IDLE.
- `in_valid` while busy: ignored; no queuing.
- `in_ready` and `out_valid` are never both high.

## Timing
- Reset values: `in_ready` = 1 (IDLE), `out_valid` = 0, `busy` = 0, `diff` = 0, `bout` = 0, `overflow` = 0, `skip_cnt` = 0, FSM = IDLE.
- Reset mid-operation: immediate abort. The in-flight result is lost and outputs return to reset values asynchronously.
- Latency:
  - Handshake at edge N. CALC occupies edges N+1 .. N+WIDTH/BLOCK.
  - `out_valid` is high after edge N+WIDTH/BLOCK: 8 cycles with defaults.
- Throughput: at best one result per WIDTH/BLOCK + 2 cycles.
  - The DONE→IDLE transition costs one cycle even when `out_ready` is held high.
- `out_ready` low: DONE is held indefinitely with outputs stable.
- `diff` upper slices may show stale bits during CALC. `diff` is valid only while `out_valid` is high.

## Configuration
- `SUB_SAT_EN` defined: when `overflow` is 1, `diff` is saturated at the transition to DONE.
  - Saturates to `0x7FFF_FFFF` if `a` is non-negative, `0x8000_0000` if `a` is negative.
  - `overflow` still reports 1. `bout` and `skip_cnt` are unaffected.
- `SUB_SAT_EN` undefined: `diff` wraps (two's complement); no saturation logic is synthesized.

## Test plan
- **Overflow into negative**: a=2147483647, b=-1, bin=0.
  - Without `SUB_SAT_EN`: diff=-2147483648, overflow=1.
  - With `SUB_SAT_EN`: diff=2147483647, overflow=1.
- **Overflow into positive**: a=-2147483648, b=1, bin=0 → diff=2147483647 (wrap), overflow=1, bout=0.
- **Mixed bypass/ripple**: a=52, b=31, bin=0 → diff=21, overflow=0, bout=0, skip_cnt=6. `out_valid` rises exactly 8 cycles after the input handshake.
- **Full bypass, zero result**: a=0, b=0, bin=0 → diff=0, bout=0, skip_cnt=8. Then a=5, b=5, bin=1 → diff=-1, bout=1, overflow=0.
- **Backpressure and busy**:
  - Stimulus: a=100, b=200; hold `out_ready`=0 for 5 cycles; pulse `in_valid` with new operands during CALC.
  - Required: diff=-100 and bout=1, held stable across the stall; the new operands are ignored; `in_ready` returns to 1 one cycle after `out_ready`.
- **Reset mid-CALC**: deassert `rst_n` at block 3.
  - `out_valid`=0, `in_ready`=1 and diff=0 immediately.
  - The next operation, 4561-89, gives diff=4472.

Source files
------------

// File: rtl/bypass_subtractor_seq.sv
// Sequential signed subtractor: a - b - bin, one carry-bypass block per clock.
// Optional macro SUB_SAT_EN saturates diff on signed overflow.
module bypass_subtractor_seq #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                a,
  input  logic [WIDTH-1:0]                b,
  input  logic                            bin,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                diff,
  output logic                            bout,
  output logic                            overflow,
  output logic [$clog2(WIDTH/BLOCK):0]    skip_cnt,
  output logic                            busy
);
  localparam int NBLK = WIDTH / BLOCK;
  localparam int IW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int CW   = $clog2(NBLK) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, nb_q, nb_d, diff_q, diff_d;
  logic              c_q, c_d, bout_q, bout_d, ovf_q, ovf_d;
  logic [IW-1:0]     blk_idx_q, blk_idx_d;
  logic [CW-1:0]     skip_q, skip_d;
  logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;

  logic [BLOCK-1:0]  blk_a, blk_nb, p, g, sum;
  logic              cc, c_out, msb_ovf;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    nb_d        = nb_q;
    c_d         = c_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    blk_idx_d   = blk_idx_q;
    skip_d      = skip_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    blk_a  = a_q[int'(blk_idx_q)*BLOCK +: BLOCK];
    blk_nb = nb_q[int'(blk_idx_q)*BLOCK +: BLOCK];
    p      = blk_a ^ blk_nb;
    g      = blk_a & blk_nb;
    sum    = '0;
    cc     = c_q;
    for (int j = 0; j < BLOCK; j++) begin
      sum[j] = p[j] ^ cc;
      cc     = g[j] | (p[j] & cc);
    end
    // A fully propagating block forwards its carry-in straight through.
    c_out   = (&p) ? c_q : cc;
    // b's sign is the inverse of the latched ~b sign.
    msb_ovf = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (sum[BLOCK-1] != a_q[WIDTH-1]);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          nb_d       = ~b;
          c_d        = ~bin;
          blk_idx_d  = '0;
          skip_d     = '0;
          state_d    = CALC;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      CALC: begin
        diff_d[int'(blk_idx_q)*BLOCK +: BLOCK] = sum;
        c_d = c_out;
        if (&p) skip_d = skip_q + 1'b1;
        if (blk_idx_q == IW'(NBLK-1)) begin
          bout_d      = ~c_out;
          ovf_d       = msb_ovf;
          state_d     = DONE;
          out_valid_d = 1'b1;
`ifdef SUB_SAT_EN
          if (msb_ovf)
            diff_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        end else begin
          blk_idx_d = blk_idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      nb_q        <= '0;
      c_q         <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      blk_idx_q   <= '0;
      skip_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      nb_q        <= nb_d;
      c_q         <= c_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      blk_idx_q   <= blk_idx_d;
      skip_q      <= skip_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign overflow  = ovf_q;
  assign skip_cnt  = skip_q;
endmodule

// File: tb/tb_bypass_subtractor_seq.sv
// Self-checking bench for bypass_subtractor_seq: directed corner cases plus random ops.
module tb_bypass_subtractor_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, bout, overflow, busy;
  logic [31:0] diff;
  logic [3:0]  skip_cnt;

  int ncmp = 0;
  int nfail = 0;

  bypass_subtractor_seq #(.WIDTH(32), .BLOCK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .overflow(overflow), .skip_cnt(skip_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic; bypassed blocks are nibbles where a and b agree.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin,
                       output logic [31:0] md, output logic mbo, output logic movf,
                       output logic [3:0] msk);
    longint r;
    r    = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mbin);
    movf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    md   = r[31:0];
`ifdef SUB_SAT_EN
    if (movf) md = ma[31] ? 32'h8000_0000 : 32'h7fff_ffff;
`endif
    mbo  = ({1'b0, ma} < ({1'b0, mb} + 33'(mbin)));
    msk  = '0;
    for (int k = 0; k < 8; k++)
      if (ma[4*k +: 4] == mb[4*k +: 4]) msk++;
  endtask

  task automatic do_op(input logic [31:0] oa, input logic [31:0] ob, input logic obin,
                       input int hold, input bit glitch);
    logic [31:0] md; logic mbo, movf; logic [3:0] msk; int cnt;
    model(oa, ob, obin, md, mbo, movf, msk);
    a = oa; b = ob; bin = obin; in_valid = 1'b1;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_calc", 64'(busy), 64'd1);
    chk("in_ready_calc", 64'(in_ready), 64'd0);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      in_valid = glitch && (cnt == 2);
      a = $urandom; b = $urandom; bin = 1'($urandom);
      @(posedge clk); #1;
      cnt++;
    end
    in_valid = 1'b0;
    chk("latency", 64'(cnt), 64'd8);
    chk("diff", 64'(diff), 64'(md));
    chk("bout", 64'(bout), 64'(mbo));
    chk("overflow", 64'(overflow), 64'(movf));
    chk("skip_cnt", 64'(skip_cnt), 64'(msk));
    chk("no_in_ready_in_done", 64'(in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_diff", 64'(diff), 64'(md));
      chk("stall_bout", 64'(bout), 64'(mbo));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_back", 64'(in_ready), 64'd1);
    chk("out_valid_drop", 64'(out_valid), 64'd0);
    chk("busy_drop", 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_diff", 64'(diff), 64'd0);
    chk("rst_bout", 64'(bout), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_skip", 64'(skip_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(32'h7fff_ffff, 32'hffff_ffff, 1'b0, 0, 1'b0);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0, 1'b0);
    do_op(32'd52, 32'd31, 1'b0, 0, 1'b0);
    do_op(32'd0, 32'd0, 1'b0, 0, 1'b0);
    do_op(32'd5, 32'd5, 1'b1, 0, 1'b0);
    do_op(32'd100, 32'd200, 1'b0, 5, 1'b1);

    // Abort mid-operation with an asynchronous reset between edges.
    a = 32'd1234; b = 32'd77; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_diff", 64'(diff), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_skip", 64'(skip_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(32'd4561, 32'd89, 1'b0, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = ra ^ (32'h1 << $urandom_range(0, 31));
        2: rb = ra;
        default: rb = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7fff_ffff;
      endcase
      do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
